// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          IFID_W           = 65;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    // Instruction word captured while decode is stalled.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fetch_buf_t;

    // PC values are always word aligned; force the low bits of any target to zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: enable + clear, clear wins over hold.
module ifid_reg
    import mips_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_en,
    input  logic  i_clr,
    input  ifid_t i_d,
    output ifid_t o_q
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

    ifid_t r_q;

    // Synchronous reset, then clear, then load on enable, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= BUBBLE;
        end else if (i_clr) begin
            r_q <= BUBBLE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/ready handshake and feeds IF/ID.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request outstanding at PC; result goes to IF/ID or buffer
// HOLD  | fetched word parked in buffer while decode is stalled; no request
// DRAIN | request at stale PC must complete before jumping to saved target
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL_D,
    input  logic        PCSRC_M,
    input  logic [31:0] PCBRANCH_M,
    input  logic        JUMP_D,
    input  logic [31:0] PCJUMP_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] INSTR_D,
    output logic [31:0] PCPLUS4_D,
    output logic        VALID_D
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_redir;
    fetch_buf_t   r_buf;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_redir_nxt;
    fetch_buf_t   w_buf_nxt;
    logic         w_req;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_branch_tgt;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_ifid_en;
    logic         w_ifid_clr;
    ifid_t        w_ifid_d;
    ifid_t        w_ifid_q;

    // Branch from M outranks a jump from D; a jump sitting in a stalled D is not yet real.
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_tgt = align_word(PCBRANCH_M);
    assign w_redirect   = PCSRC_M | (JUMP_D & ~STALL_D);
    assign w_target     = PCSRC_M ? w_branch_tgt : align_word(PCJUMP_D);

    // State, PC, buffer and saved-redirect registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= FETCH;
            r_pc    <= align_word(RESET_PC);
            r_redir <= 32'h0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_redir <= w_redir_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    // Next-state, PC update and IF/ID control.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redir_nxt = r_redir;
        w_buf_nxt   = r_buf;
        w_req       = 1'b0;
        w_ifid_en   = 1'b0;
        w_ifid_clr  = 1'b0;
        w_ifid_d    = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (imem_ready) begin
                    if (w_redirect) begin
                        w_pc_nxt   = w_target;
                        w_ifid_clr = 1'b1;
                    end else if (!STALL_D) begin
                        w_ifid_en = 1'b1;
                        w_ifid_d  = '{instr: imem_rdata, pcplus4: w_pc_plus4, valid: 1'b1};
                        w_pc_nxt  = w_pc_plus4;
                    end else begin
                        w_buf_nxt   = '{instr: imem_rdata, pcplus4: w_pc_plus4};
                        w_pc_nxt    = w_pc_plus4;
                        w_state_nxt = HOLD;
                    end
                end else if (w_redirect) begin
                    // Address must stay stable until ready, so park the target.
                    w_redir_nxt = w_target;
                    w_ifid_clr  = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (!STALL_D) begin
                    w_ifid_en = 1'b1;
                end
            end

            HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_ifid_clr  = 1'b1;
                    w_state_nxt = FETCH;
                end else if (!STALL_D) begin
                    w_ifid_en   = 1'b1;
                    w_ifid_d    = '{instr: r_buf.instr, pcplus4: r_buf.pcplus4, valid: 1'b1};
                    w_state_nxt = FETCH;
                end
            end

            DRAIN: begin
                w_req = 1'b1;
                // IF/ID is empty here, so only a branch from M can redirect; it is older and wins.
                if (PCSRC_M) begin
                    w_redir_nxt = w_branch_tgt;
                    w_ifid_clr  = 1'b1;
                end else if (!STALL_D) begin
                    w_ifid_en = 1'b1;
                end
                if (imem_ready) begin
                    w_pc_nxt    = PCSRC_M ? w_branch_tgt : r_redir;
                    w_state_nxt = FETCH;
                end
            end

            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_en    (w_ifid_en),
        .i_clr   (w_ifid_clr),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign imem_req  = w_req & RESET;
    assign imem_addr = r_pc;
    assign INSTR_D   = w_ifid_q.instr;
    assign PCPLUS4_D = w_ifid_q.pcplus4;
    assign VALID_D   = w_ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID words.
module tb_fetch_stage;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam int          M_BUB  = 0;
    localparam int          M_NEW  = 1;
    localparam int          M_HOLD = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        STALL_D;
    logic        PCSRC_M;
    logic [31:0] PCBRANCH_M;
    logic        JUMP_D;
    logic [31:0] PCJUMP_D;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] INSTR_D;
    logic [31:0] PCPLUS4_D;
    logic        VALID_D;

    int          errors = 0;
    int          checks = 0;
    int          step_no = 0;
    exp_t        sb[$];
    logic [31:0] last_instr = 32'h0;
    logic [31:0] last_pc4   = 32'h0;
    logic        last_valid = 1'b0;

    fetch_stage dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .STALL_D    (STALL_D),
        .PCSRC_M    (PCSRC_M),
        .PCBRANCH_M (PCBRANCH_M),
        .JUMP_D     (JUMP_D),
        .PCJUMP_D   (PCJUMP_D),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .INSTR_D    (INSTR_D),
        .PCPLUS4_D  (PCPLUS4_D),
        .VALID_D    (VALID_D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout step=%0d", step_no);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] pc4);
        exp_t e;
        e.instr = addr ^ KEY;
        e.pc4   = pc4;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, clock once, then check IF/ID and the fetch request.
    task automatic step(input logic rst, input logic rdy, input logic stl,
                        input logic psrc, input logic [31:0] pbr,
                        input logic jmp, input logic [31:0] pj,
                        input int mode, input logic ereq, input logic [31:0] eaddr);
        exp_t e;
        step_no++;
        RESET      = rst;
        imem_ready = rdy;
        STALL_D    = stl;
        PCSRC_M    = psrc;
        PCBRANCH_M = pbr;
        JUMP_D     = jmp;
        PCJUMP_D   = pj;
        imem_rdata = imem_addr ^ KEY;
        @(posedge CLK);
        #1;
        if (mode == M_NEW) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty step=%0d observed=0 expected=1", step_no);
            end else begin
                e = sb.pop_front();
                last_instr = e.instr;
                last_pc4   = e.pc4;
                last_valid = 1'b1;
            end
        end else if (mode == M_BUB) begin
            last_instr = 32'h0;
            last_valid = 1'b0;
        end
        chk("valid_d", {31'h0, VALID_D}, {31'h0, last_valid});
        chk("instr_d", INSTR_D, last_instr);
        if (last_valid) chk("pcplus4_d", PCPLUS4_D, last_pc4);
        chk("imem_req", {31'h0, imem_req}, {31'h0, ereq});
        chk("imem_addr", imem_addr, eaddr);
    endtask

    initial begin
        RESET = 1'b0; STALL_D = 1'b0; PCSRC_M = 1'b0; PCBRANCH_M = 32'h0;
        JUMP_D = 1'b0; PCJUMP_D = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

        // reset held for two edges
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, M_BUB, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, M_BUB, 0, 32'h0);
        RESET = 1'b1;
        #1;
        chk("req_after_release", {31'h0, imem_req}, 32'h1);
        chk("addr_after_release", imem_addr, 32'h0);

        // zero-wait stream
        push(32'h0, 32'h4);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h4);
        push(32'h4, 32'h8);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h8);

        // two wait states at 0x8
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, M_BUB, 1, 32'h8);
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, M_BUB, 1, 32'h8);
        push(32'h8, 32'hC);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'hC);

        // stall on return at 0xC, held three cycles
        push(32'hC, 32'h10);
        step(1, 1, 1, 0, 32'h0, 0, 32'h0, M_HOLD, 0, 32'h10);
        step(1, 0, 1, 0, 32'h0, 0, 32'h0, M_HOLD, 0, 32'h10);
        step(1, 0, 1, 0, 32'h0, 0, 32'h0, M_HOLD, 0, 32'h10);
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h10);

        // branch while waiting at 0x14
        push(32'h10, 32'h14);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h14);
        step(1, 0, 0, 1, 32'h40, 0, 32'h0, M_BUB, 1, 32'h14);
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, M_BUB, 1, 32'h14);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_BUB, 1, 32'h40);

        // branch beats jump; then a jump under stall is ignored
        step(1, 1, 0, 1, 32'h100, 1, 32'h80, M_BUB, 1, 32'h100);
        step(1, 0, 1, 0, 32'h0, 1, 32'h80, M_HOLD, 1, 32'h100);
        push(32'h100, 32'h104);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h104);

        // misaligned target is aligned; PC+4 wraps to zero
        step(1, 1, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, M_BUB, 1, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h0);

        // newer branches overwrite the saved target during drain, last one same cycle as ready
        step(1, 0, 0, 1, 32'h200, 0, 32'h0, M_BUB, 1, 32'h0);
        step(1, 0, 0, 1, 32'h300, 0, 32'h0, M_BUB, 1, 32'h0);
        step(1, 1, 0, 1, 32'h400, 0, 32'h0, M_BUB, 1, 32'h400);

        // jump out of HOLD discards the buffered word
        step(1, 1, 1, 0, 32'h0, 0, 32'h0, M_HOLD, 0, 32'h404);
        step(1, 0, 1, 0, 32'h0, 1, 32'h500, M_HOLD, 0, 32'h404);
        step(1, 0, 0, 0, 32'h0, 1, 32'h83, M_BUB, 1, 32'h80);
        push(32'h80, 32'h84);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h84);

        // reset mid-transaction
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, M_BUB, 0, 32'h0);
        RESET = 1'b1;
        #1;
        chk("req_after_rereset", {31'h0, imem_req}, 32'h1);
        chk("addr_after_rereset", imem_addr, 32'h0);
        push(32'h0, 32'h4);
        step(1, 1, 0, 0, 32'h0, 0, 32'h0, M_NEW, 1, 32'h4);

        chk("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
